// File: rtl/mdio_pkg.sv
// mdio_pkg: Clause 22 MDIO constants, field widths and FSM encoding shared by controller and target
package mdio_pkg;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;
  localparam int TA_W    = 2;
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
  } state_t;
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: 2-flop synchroniser; EDGE=1 returns a registered rising-edge pulse, EDGE=0 the synced level
module mdio_sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] s;
  logic prev, pulse;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s <= '0;
      prev <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s <= {s[0], d};
      prev <= s[1];
      pulse <= s[1] & ~prev;
    end
  assign q = EDGE ? pulse : s[1];
endmodule

// File: rtl/mdio_target.sv
// mdio_target: Clause 22 MDIO PHY-side target; decodes frames, strobes writes and serialises read data
module mdio_target
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd0,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mdc,
  input  logic                mdio_out,
  input  logic                mdio_oe,
  output logic                mdio_in,
  output logic                mdio_in_oe,
  output logic [REGAD_W-1:0]  addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr_stb,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                frame_err
);
  state_t state, state_n;
  logic tick, bus, match, rd, cap;
  logic err_n, wr_n, ld_n, rs_n, in_n, oe_n;
  logic [4:0] cnt;
  logic [5:0] pre;
  logic [DATA_W-1:0] sh, rsr;
  logic [1:0] pair;

  mdio_sync_edge #(.EDGE(1'b1)) u_mdc (.clk(clk), .reset(reset), .d(mdc), .q(tick));
  mdio_sync_edge #(.EDGE(1'b0)) u_bus (.clk(clk), .reset(reset), .d(mdio_oe ? mdio_out : 1'b1), .q(bus));

  // two-bit fields (OP, TA) are judged on their second bit using the previous bit held in sh[0]
  assign pair = {sh[0], bus};

  always_comb begin
    state_n = state;
    err_n = 1'b0;
    wr_n = 1'b0;
    ld_n = 1'b0;
    rs_n = 1'b0;
    in_n = mdio_in;
    oe_n = mdio_in_oe;
    if (tick)
      case (state)
        S_IDLE:  if (!bus && 32'(pre) >= PREAMBLE_LEN) state_n = S_START;
        S_START: begin
          state_n = bus == ST[0] ? S_OP : S_IDLE;
          err_n = bus != ST[0];
        end
        S_OP: if (cnt[0]) begin
          state_n = (pair == OP_WRITE || pair == OP_READ) ? S_PHYAD : S_IDLE;
          err_n = !(pair == OP_WRITE || pair == OP_READ);
        end
        S_PHYAD: if (cnt == 5'd4) state_n = S_REGAD;
        S_REGAD: if (cnt == 5'd4) begin
          state_n = match ? S_TA : S_SKIP;
          ld_n = match;
        end
        S_TA:
          if (!cnt[0]) begin
            in_n = 1'b0;
            oe_n = rd;
          end else if (rd) begin
            state_n = S_RDATA;
            in_n = rsr[DATA_W-1];
            rs_n = 1'b1;
          end else begin
            state_n = pair == 2'b10 ? S_WDATA : S_IDLE;
            err_n = pair != 2'b10;
          end
        S_WDATA: if (cnt == 5'd15) begin
          state_n = S_IDLE;
          wr_n = 1'b1;
        end
        S_RDATA:
          if (cnt == 5'd15) begin
            state_n = S_IDLE;
            in_n = 1'b0;
            oe_n = 1'b0;
          end else begin
            in_n = rsr[DATA_W-1];
            rs_n = 1'b1;
          end
        S_SKIP: if (cnt == 5'd17) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      pre <= '0;
      sh <= '0;
      rsr <= '0;
      match <= 1'b0;
      rd <= 1'b0;
      cap <= 1'b0;
      addr <= '0;
      wr_data <= '0;
      wr_stb <= 1'b0;
      frame_err <= 1'b0;
      mdio_in <= 1'b0;
      mdio_in_oe <= 1'b0;
    end else begin
      state <= state_n;
      frame_err <= err_n;
      wr_stb <= wr_n;
      mdio_in <= in_n;
      mdio_in_oe <= oe_n;
      cap <= ld_n & rd;
      cnt <= state_n != state ? 5'd0 : cnt + {4'd0, tick};
      if (state != S_IDLE) pre <= '0;
      else if (tick) pre <= bus ? pre + {5'd0, ~&pre} : '0;
      if (tick) sh <= {sh[DATA_W-2:0], bus};
      if (tick && state == S_OP) rd <= pair == OP_READ;
      if (tick && state == S_PHYAD && cnt == 5'd4) match <= {sh[3:0], bus} == PHY_ADDR;
      if (ld_n) addr <= {sh[3:0], bus};
      if (wr_n) wr_data <= {sh[DATA_W-2:0], bus};
      // rd_data follows addr combinationally, so it is captured the clk after addr loads
      if (cap) rsr <= rd_data;
      else if (rs_n) rsr <= {rsr[DATA_W-2:0], 1'b0};
    end
endmodule

// File: doc/mdio_target.md
# mdio_target

PHY-side Clause 22 (IEEE 802.3) MDIO management target. Sits directly downstream of the MDIO `controller`. It samples the serial frame the controller drives on `mdio_out`/`mdio_oe`, then decodes preamble, start, opcode, PHY address and register address. It issues writes to the register file on `addr`/`wr_data`/`wr_stb`, and serialises `rd_data` back to the controller on `mdio_in` for reads.

## Interface
- `PHY_ADDR`, default 5'd0: PHY address this target answers to.
- `PREAMBLE_LEN`, default 32: minimum count of consecutive 1 bits required before a start.
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `mdc` in 1: management clock from the controller, asynchronous to `clk`, frequency ≤ clk/4.
- `mdio_out` in 1: serial data driven by the controller.
- `mdio_oe` in 1: controller drive enable.
  - Bus bit = `mdio_oe ? mdio_out : 1`, which models the pull-up.
- `mdio_in` out 1: serial data driven back to the controller.
- `mdio_in_oe` out 1: target drive enable.
- `addr` out 5: register address of the current frame.
- `wr_data` out 16: write data.
- `wr_stb` out 1: single-cycle write strobe.
- `rd_data` in 16: register-file read data for `addr`, combinational from the register file.
- `frame_err` out 1: single-cycle pulse on a malformed frame.

## Operation
- `mdc` and the bus bit each pass through a 2-flop synchroniser.
- One frame bit is consumed per detected `mdc` rising edge, the "bit tick".
- FSM states: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP.
- **IDLE**
  - Saturating 6-bit preamble counter: increments on bit 1, clears on bit 0.
  - A 0 bit with count ≥ PREAMBLE_LEN goes to START.
- **START**
  - Next bit must be 1 (ST = 01) → OP.
  - Otherwise `frame_err`, go to IDLE, counter cleared.
- **OP**
  - 2 bits, MSB first.
  - 01 = write, 10 = read.
  - 00 or 11 → `frame_err`, go to IDLE.
- **PHYAD**
  - 5 bits, MSB first.
  - Compared with PHY_ADDR at the end of the field.
- **REGAD**
  - 5 bits, MSB first.
  - On the last bit with PHYAD match: `addr` is loaded.
  - For a read, `rd_data` is captured into a 16-bit shift register one clk later.
  - On PHYAD mismatch, go to SKIP.
- **TA**, 2 bits
  - Write: expects 1 then 0; any other value → `frame_err`, go to IDLE.
  - Read: target leaves `mdio_in_oe`=0 for the first TA bit, then drives `mdio_in`=0 with `mdio_in_oe`=1 for the second.
- **WDATA**
  - 16 bits shifted MSB first.
  - After the 16th bit: `wr_data` is loaded and `wr_stb` pulses, then go to IDLE.
- **RDATA**
  - Drives shift-register MSB first, one bit per tick, for 16 ticks.
  - Then `mdio_in_oe`=0, go to IDLE.
- **SKIP**
  - Consumes 18 ticks (TA + data) without driving or strobing, then goes to IDLE.
- Preamble counter is cleared on every return to IDLE.
- Back-to-back frames therefore need a full new preamble.
- Data fields are ignored while `reset` is low.

## Timing
- Bit tick occurs 3 clk after an `mdc` rising edge at the pin: 2 sync flops plus edge-detect register.
- `mdio_in`/`mdio_in_oe` update on the clk following a bit tick.
  - This gives the controller a stable value before the next `mdc` rise.
- `wr_stb` is high for exactly 1 clk, the clk after the tick of data bit 0.
- `wr_data` is updated in that same cycle and held until the next write.
- `addr` is valid from 1 clk after the REGAD last-bit tick and held until the next matching frame's REGAD.
- `frame_err` is high for 1 clk, on the clk after the offending tick.
- Reset values:
  - `mdio_in`=0, `mdio_in_oe`=0.
  - `addr`=0, `wr_data`=0.
  - `wr_stb`=0, `frame_err`=0.
  - State IDLE, counters 0.
- Reset asserted mid-frame: outputs go to their reset values immediately (async) and any pending strobe is lost.
- `mdc` stopping mid-frame leaves the FSM waiting; there is no timeout.

## Structure
- Package `mdio_pkg` holds:
  - OP_WRITE=2'b01, OP_READ=2'b10, ST=2'b01.
  - Field widths (PHYAD/REGAD 5, DATA 16, TA 2).
  - FSM state encoding.
- This package is shared with `controller`.
- Sub-module `mdio_sync_edge`: 2-flop synchroniser with rising-edge pulse. Instantiated once for `mdc`; the bus bit uses a plain 2-flop instance.

## Test plan
- **Write:** 32×1 preamble, ST 01, OP 01, PHYAD 0, REGAD 5'd4, TA 10, data 16'hABCD → `addr`=4, `wr_data`=16'hABCD, one `wr_stb` pulse, `mdio_in_oe` never high.
- **Read:** same header with OP 10, REGAD 5'd2, `rd_data`=16'hFEED → `mdio_in_oe` low on TA bit 1, `mdio_in`=0 on TA bit 2, then serial 1111_1110_1110_1101 MSB first, then `mdio_in_oe`=0.
- **PHYAD mismatch:** PHY_ADDR=0, frame to PHYAD 5'd3 with data 16'hFFFF → no `wr_stb`, no drive, `addr` unchanged; a following valid write to REGAD 1 is accepted.
- **Framing errors:** OP 11 → one `frame_err`, no strobe. Write TA 00 → one `frame_err`. Preamble of 31 ones → start ignored, no `frame_err`, no strobe.
- **Reset mid-frame:** `reset` low during WDATA bit 8 → all outputs at reset values, no `wr_stb`. After release, a full write of 16'hCAFE to REGAD 7 succeeds.
